// File: rtl/cnn_pkg.sv
// cnn_pkg: shared word width, 3x3 window slot indices and window-generator state encoding.
package cnn_pkg;

  localparam int DATA_W = 32;

  // Row-major slots of a 3x3 window: T/M/B = top/middle/bottom, L/C/R = left/centre/right.
  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } win_state_t;

endpackage

// File: rtl/line_buffer_row.sv
// line_buffer_row: DEPTH-word circular delay line; o_data is the word shifted in DEPTH shifts ago.
module line_buffer_row
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 28,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_ptr;

  // Read-before-write at the same slot turns the RAM into a fixed DEPTH-step delay.
  assign o_data = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_shift) begin
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_generator.sv
// conv_window_generator: raster pixel stream in, held 3x3 windows out with a win_ack handshake.
// Define CONV_WINDOW_ZERO_PAD_EN for same-size output with an internally injected zero border.
module conv_window_generator
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [9*DATA_W-1:0] window_out,
  output logic                window_valid,
  input  logic                win_ack,
  output logic                frame_done
);

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam int GW = IMG_W + 2;
  localparam int GH = IMG_H + 2;
`else
  localparam int GW = IMG_W;
  localparam int GH = IMG_H;
`endif
  localparam int CW = $clog2(GW);
  localparam int RW = $clog2(GH);
  localparam logic [CW-1:0] VC_LAST = CW'(GW - 1);
  localparam logic [RW-1:0] VR_LAST = RW'(GH - 1);
  localparam logic [CW-1:0] VC_MIN  = CW'(2);
  localparam logic [RW-1:0] VR_MIN  = RW'(2);

  win_state_t          r_state;
  win_state_t          w_state_nxt;
  logic [CW-1:0]       r_vc;
  logic [RW-1:0]       r_vr;
  logic                r_last;
  logic [9*DATA_W-1:0] r_window;

  logic              w_open;
  logic              w_border;
  logic              w_step;
  logic              w_complete;
  logic              w_at_last;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_row1;
  logic [DATA_W-1:0] w_row2;

  assign w_open = (r_state == FILL) || (r_state == RUN);

`ifdef CONV_WINDOW_ZERO_PAD_EN
  assign w_border = (r_vr == '0) || (r_vr == VR_LAST) || (r_vc == '0) || (r_vc == VC_LAST);
`else
  assign w_border = 1'b0;
`endif

  // A grid step is either an accepted pixel or a self-timed zero on the padding border.
  assign pix_ready  = !rst && w_open && !w_border;
  assign w_step     = (pix_valid && pix_ready) || (w_open && w_border);
  assign w_word     = w_border ? '0 : pix_in;
  assign w_complete = w_step && (r_vr >= VR_MIN) && (r_vc >= VC_MIN);
  assign w_at_last  = (r_vc == VC_LAST) && (r_vr == VR_LAST);

  line_buffer_row #(.DEPTH(GW), .DATA_W(DATA_W)) u_lb_row1 (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_step),
    .i_data  (w_word),
    .o_data  (w_row1)
  );

  line_buffer_row #(.DEPTH(GW), .DATA_W(DATA_W)) u_lb_row2 (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_step),
    .i_data  (w_row1),
    .o_data  (w_row2)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL, RUN: if (w_complete) w_state_nxt = HOLD;
      HOLD:      if (win_ack) w_state_nxt = r_last ? DONE : RUN;
      DONE:      w_state_nxt = FILL;
      default:   w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_vc    <= '0;
      r_vr    <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DONE) begin
        r_vc <= '0;
        r_vr <= '0;
      end else if (w_step) begin
        if (r_vc == VC_LAST) begin
          r_vc <= '0;
          r_vr <= (r_vr == VR_LAST) ? '0 : r_vr + 1'b1;
        end else begin
          r_vc <= r_vc + 1'b1;
        end
      end
      if (w_complete) begin
        r_last <= w_at_last;
      end
    end
  end

  // Each step shifts the window one column left; the new right column is (row r-2, r-1, r).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window <= '0;
    end else if (w_step) begin
      r_window[W_TL*DATA_W +: DATA_W] <= r_window[W_TC*DATA_W +: DATA_W];
      r_window[W_TC*DATA_W +: DATA_W] <= r_window[W_TR*DATA_W +: DATA_W];
      r_window[W_TR*DATA_W +: DATA_W] <= w_row2;
      r_window[W_ML*DATA_W +: DATA_W] <= r_window[W_MC*DATA_W +: DATA_W];
      r_window[W_MC*DATA_W +: DATA_W] <= r_window[W_MR*DATA_W +: DATA_W];
      r_window[W_MR*DATA_W +: DATA_W] <= w_row1;
      r_window[W_BL*DATA_W +: DATA_W] <= r_window[W_BC*DATA_W +: DATA_W];
      r_window[W_BC*DATA_W +: DATA_W] <= r_window[W_BR*DATA_W +: DATA_W];
      r_window[W_BR*DATA_W +: DATA_W] <= w_word;
    end
  end

  assign window_out   = r_window;
  assign window_valid = (r_state == HOLD);
  assign frame_done   = (r_state == DONE);

endmodule

// File: tb/tb_conv_window_generator.sv
// tb_conv_window_generator: scoreboard bench for a 4x4 and a 5x3 instance; expected windows are
// computed from the whole image array, a monitor acks windows with varying delay and compares.
module tb_conv_window_generator;

  localparam int DW = 32;
  localparam int NW = 9 * DW;
  typedef logic [NW-1:0] win_t;
  typedef struct {
    win_t win;
    bit   last;
  } exp_t;

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  function automatic void check(input string name, input int cfg, input win_t act, input win_t req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s (cfg %0d): got %0h, required %0h", name, cfg, act, req);
    end
  endfunction

  function automatic void flag(input string name, input int cfg);
    n_checks++;
    n_fails++;
    $display("FAIL %s (cfg %0d): got no response, required one within the cycle bound", name, cfg);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : blk
    localparam int W    = (g == 0) ? 4 : 5;
    localparam int H    = (g == 0) ? 4 : 3;
    localparam int NPIX = W * H;

    logic          rst       = 1'b1;
    logic [DW-1:0] pix_in    = '0;
    logic          pix_valid = 1'b0;
    logic          win_ack   = 1'b0;
    logic          pix_ready;
    logic          window_valid;
    logic          frame_done;
    win_t          window_out;
    logic          rst_q     = 1'b1;

    logic [DW-1:0] img [NPIX];
    exp_t          exp_q [$];
    bit            rand_ack = 1'b0;
    bit            finished = 1'b0;
    int            bp_index = -1;
    int            n_taken  = 0;
    int            fd_seen  = 0;

    conv_window_generator #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .window_out   (window_out),
      .window_valid (window_valid),
      .win_ack      (win_ack),
      .frame_done   (frame_done)
    );

    always @(posedge clk) rst_q <= rst;

    // Reference: every output position (r,c) sees the 3x3 image neighbourhood, zero outside.
    task automatic load_expect();
      int nr = PAD ? H : H - 2;
      int nc = PAD ? W : W - 2;
      int off = PAD ? 1 : 0;
      for (int r = 0; r < nr; r++) begin
        for (int c = 0; c < nc; c++) begin
          exp_t e;
          e.win = '0;
          for (int i = 0; i < 9; i++) begin
            int rr = r + i / 3 - off;
            int cc = c + i % 3 - off;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) e.win[i*DW +: DW] = img[rr*W + cc];
          end
          e.last = (r == nr - 1) && (c == nc - 1);
          exp_q.push_back(e);
        end
      end
    endtask

    task automatic push_pix(input logic [DW-1:0] p);
      int t = 0;
      pix_in    = p;
      pix_valid = 1'b1;
      while (!pix_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!pix_ready) flag("pixel_accept", g);
      @(negedge clk);
    endtask

    task automatic do_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
      #1 check("ready_after_reset", g, win_t'(pix_ready), win_t'(!PAD));
    endtask

    task automatic send_frame(input bit rnd, input int base, input int npix, input bit keep_valid);
      for (int k = 0; k < NPIX; k++) img[k] = rnd ? $urandom : DW'(base + k + 1);
      load_expect();
      for (int k = 0; k < npix; k++) begin
        push_pix(img[k]);
        if (!keep_valid) begin
          pix_valid = 1'b0;
          if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    endtask

    task automatic wait_frame(input int fd_target);
      int t = 0;
      pix_valid = 1'b0;
      while ((exp_q.size() != 0 || fd_seen < fd_target) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("frames_done", g, win_t'(fd_seen), win_t'(fd_target));
      check("windows_left", g, win_t'(exp_q.size()), '0);
    endtask

    initial begin : mon
      win_t held;
      bit   holding;
      bit   fd_expect;
      int   wait_cnt;
      int   delay;
      exp_t e;
      held      = '0;
      holding   = 1'b0;
      fd_expect = 1'b0;
      wait_cnt  = 0;
      delay     = 0;
      forever begin
        @(negedge clk);
        if (rst || rst_q) begin
          win_ack   = 1'b0;
          holding   = 1'b0;
          wait_cnt  = 0;
          fd_expect = 1'b0;
          if (rst && rst_q) begin
            check("reset_flags", g, win_t'({pix_ready, window_valid, frame_done}), '0);
            check("reset_window", g, window_out, '0);
          end
        end else begin
          if (fd_expect || frame_done) begin
            check("frame_done", g, win_t'(frame_done), win_t'(fd_expect));
            if (frame_done) fd_seen++;
          end
          fd_expect = 1'b0;
          if (window_valid) begin
            if (!holding) begin
              held     = window_out;
              holding  = 1'b1;
              wait_cnt = 0;
              delay    = (n_taken == bp_index) ? 5 : (rand_ack ? int'($urandom_range(0, 3)) : 0);
            end else begin
              check("hold_stable", g, window_out, held);
            end
            check("hold_ready", g, win_t'(pix_ready), '0);
            if (wait_cnt >= delay) begin
              if (exp_q.size() == 0) begin
                flag("extra_window", g);
              end else begin
                e = exp_q.pop_front();
                check("window", g, window_out, e.win);
                fd_expect = e.last;
              end
              n_taken++;
              win_ack = 1'b1;
              holding = 1'b0;
            end else begin
              win_ack = 1'b0;
              wait_cnt++;
            end
          end else begin
            holding = 1'b0;
            win_ack = rand_ack && ($urandom_range(0, 3) == 0);
          end
        end
      end
    end

    initial begin : script
      repeat (2) @(negedge clk);
      do_reset();
      send_frame(1'b0, 0, NPIX, 1'b0);
      wait_frame(1);
      bp_index = n_taken;
      send_frame(1'b0, 0, NPIX, 1'b0);
      wait_frame(2);
      send_frame(1'b0, 0, 7, 1'b0);
      do_reset();
      send_frame(1'b0, 0, NPIX, 1'b0);
      wait_frame(3);
      send_frame(1'b0, 0, NPIX, 1'b1);
      send_frame(1'b0, NPIX, NPIX, 1'b1);
      wait_frame(5);
      rand_ack = 1'b1;
      for (int f = 0; f < 6; f++) begin
        send_frame(1'b1, 0, NPIX, 1'b0);
        wait_frame(6 + f);
      end
      finished = 1'b1;
    end
  end

  initial begin : summary
    int t = 0;
    while (!(blk[0].finished && blk[1].finished) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    if (!(blk[0].finished && blk[1].finished)) flag("run_complete", -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
